// File: rtl/dram_test_gen_pkg.sv
// Shared DRAM request-encoding definitions for every producer/consumer of the
// request FIFO, plus the test-generator state type and small helpers.
package dram_test_gen_pkg;

    localparam int REQ_WR_BIT = 0;
    localparam logic REQ_WRITE = 1'b1;
    localparam logic REQ_READ = 1'b0;
    localparam int ERR_COUNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } tg_state_e;

    // Request word = write flag plus page address above it.
    function automatic int req_size(input int log_addr_size);
        return 1 + log_addr_size;
    endfunction

    function automatic logic [ERR_COUNT_W-1:0] sat_inc(input logic [ERR_COUNT_W-1:0] v);
        logic [ERR_COUNT_W-1:0] r;
        if (v == {ERR_COUNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(ERR_COUNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/dram_test_gen_checker.sv
// Read-page comparator: sticky mismatch flag and saturating error counter.
module dram_page_checker
    import dram_test_gen_pkg::*;
#(
    parameter int PAGE_LEN = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   cmp_en,
    input  logic [PAGE_LEN-1:0]    actual,
    input  logic [PAGE_LEN-1:0]    expected,
    output logic                   mismatch,
    output logic [ERR_COUNT_W-1:0] err_count
);

    logic miss_s;

    // Flag a compare whose page differs from the expected pattern.
    always_comb begin
        miss_s = 1'b0;
        if (cmp_en && (actual != expected)) begin
            miss_s = 1'b1;
        end else begin
            miss_s = 1'b0;
        end
    end

    // Sticky flag and counter; the counter holds at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch  <= 1'b0;
            err_count <= {ERR_COUNT_W{1'b0}};
        end else if (clear) begin
            mismatch  <= 1'b0;
            err_count <= {ERR_COUNT_W{1'b0}};
        end else if (miss_s) begin
            mismatch  <= 1'b1;
            err_count <= sat_inc(err_count);
        end else begin
            mismatch  <= mismatch;
            err_count <= err_count;
        end
    end

endmodule

// File: rtl/dram_test_gen.sv
// DRAM self-test generator: writes pattern a to every page a, reads all pages
// back and checks them, with request issue and response drain fully decoupled.
module dram_test_gen
    import dram_test_gen_pkg::*;
#(
    parameter int LOG_DRAM_SIZE = 6,
    parameter int PAGE_LEN      = 32,
    parameter int LOG_ADDR_SIZE = LOG_DRAM_SIZE - $clog2(PAGE_LEN),
    parameter int LOG_REQ_SIZE  = req_size(LOG_ADDR_SIZE)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    frq_write_en,
    output logic [LOG_REQ_SIZE-1:0] frq_write_data,
    input  logic                    frq_full,
    output logic                    fin_write_en,
    output logic [PAGE_LEN-1:0]     fin_write_data,
    input  logic                    fin_full,
    output logic                    fout_read_en,
    input  logic [PAGE_LEN-1:0]     fout_read_data,
    input  logic                    fout_empty,
    output logic                    busy,
    output logic                    done,
    output logic                    mismatch,
    output logic [7:0]              err_count
);

    localparam int ADDR_W = LOG_ADDR_SIZE + 1;
    localparam logic [ADDR_W-1:0] NUM_PAGES = {1'b1, {LOG_ADDR_SIZE{1'b0}}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{LOG_ADDR_SIZE{1'b0}}, 1'b1};

    tg_state_e             state_r, state_s;
    logic [ADDR_W-1:0]     wr_addr_r, wr_addr_s;
    logic [ADDR_W-1:0]     rd_addr_r, rd_addr_s;
    logic [ADDR_W-1:0]     rx_addr_r, rx_addr_s;
    logic                  frq_we_s;
    logic [LOG_REQ_SIZE-1:0] frq_wd_s;
    logic                  fin_we_s;
    logic [PAGE_LEN-1:0]   fin_wd_s;
    logic                  fout_re_s;
    logic                  busy_s;
    logic                  done_s;
    logic                  clear_s;
    logic [PAGE_LEN-1:0]   exp_page_s;

    function automatic logic [LOG_REQ_SIZE-1:0] make_req(input logic [LOG_ADDR_SIZE-1:0] addr,
                                                        input logic is_write);
        logic [LOG_REQ_SIZE-1:0] req;
        req = {LOG_REQ_SIZE{1'b0}};
        req[REQ_WR_BIT] = is_write;
        req[LOG_REQ_SIZE-1:REQ_WR_BIT+1] = addr;
        return req;
    endfunction

    function automatic logic [PAGE_LEN-1:0] pattern(input logic [LOG_ADDR_SIZE-1:0] addr);
        return {{(PAGE_LEN-LOG_ADDR_SIZE){1'b0}}, addr};
    endfunction

    // Expected page for the response currently being popped.
    always_comb begin
        exp_page_s = pattern(rx_addr_r[LOG_ADDR_SIZE-1:0]);
    end

    // Next-state and next-output logic; pulses are spaced by the previous-cycle guards.
    always_comb begin
        state_s   = state_r;
        wr_addr_s = wr_addr_r;
        rd_addr_s = rd_addr_r;
        rx_addr_s = rx_addr_r;
        frq_we_s  = 1'b0;
        frq_wd_s  = frq_write_data;
        fin_we_s  = 1'b0;
        fin_wd_s  = fin_write_data;
        fout_re_s = 1'b0;
        clear_s   = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_s   = ST_WRITE;
                    wr_addr_s = {ADDR_W{1'b0}};
                    rd_addr_s = {ADDR_W{1'b0}};
                    rx_addr_s = {ADDR_W{1'b0}};
                    clear_s   = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            ST_WRITE: begin
                if (wr_addr_r == NUM_PAGES) begin
                    state_s   = ST_READ;
                    rd_addr_s = {ADDR_W{1'b0}};
                    rx_addr_s = {ADDR_W{1'b0}};
                end else if (!frq_full && !fin_full && !frq_write_en) begin
                    frq_we_s  = 1'b1;
                    frq_wd_s  = make_req(wr_addr_r[LOG_ADDR_SIZE-1:0], REQ_WRITE);
                    fin_we_s  = 1'b1;
                    fin_wd_s  = pattern(wr_addr_r[LOG_ADDR_SIZE-1:0]);
                    wr_addr_s = wr_addr_r + ADDR_ONE;
                end else begin
                    wr_addr_s = wr_addr_r;
                end
            end
            ST_READ: begin
                if ((rd_addr_r < NUM_PAGES) && !frq_full && !frq_write_en) begin
                    frq_we_s  = 1'b1;
                    frq_wd_s  = make_req(rd_addr_r[LOG_ADDR_SIZE-1:0], REQ_READ);
                    rd_addr_s = rd_addr_r + ADDR_ONE;
                end else begin
                    rd_addr_s = rd_addr_r;
                end
                // The page under fout_read_en is compared on this edge and popped by the FIFO.
                if (fout_read_en) begin
                    rx_addr_s = rx_addr_r + ADDR_ONE;
                end else if ((rx_addr_r < NUM_PAGES) && !fout_empty) begin
                    fout_re_s = 1'b1;
                end else begin
                    rx_addr_s = rx_addr_r;
                end
                if (rx_addr_r == NUM_PAGES) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_READ;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        busy_s = (state_s == ST_WRITE) || (state_s == ST_READ);
        done_s = (state_s == ST_DONE);
    end

    // State, counters and all request/handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            wr_addr_r      <= {ADDR_W{1'b0}};
            rd_addr_r      <= {ADDR_W{1'b0}};
            rx_addr_r      <= {ADDR_W{1'b0}};
            frq_write_en   <= 1'b0;
            frq_write_data <= {LOG_REQ_SIZE{1'b0}};
            fin_write_en   <= 1'b0;
            fin_write_data <= {PAGE_LEN{1'b0}};
            fout_read_en   <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            state_r        <= state_s;
            wr_addr_r      <= wr_addr_s;
            rd_addr_r      <= rd_addr_s;
            rx_addr_r      <= rx_addr_s;
            frq_write_en   <= frq_we_s;
            frq_write_data <= frq_wd_s;
            fin_write_en   <= fin_we_s;
            fin_write_data <= fin_wd_s;
            fout_read_en   <= fout_re_s;
            busy           <= busy_s;
            done           <= done_s;
        end
    end

    dram_page_checker #(
        .PAGE_LEN(PAGE_LEN)
    ) u_checker (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear_s),
        .cmp_en    (fout_read_en),
        .actual    (fout_read_data),
        .expected  (exp_page_s),
        .mismatch  (mismatch),
        .err_count (err_count)
    );

endmodule

// File: tb/tb_dram_test_gen.sv
// Bench for dram_test_gen with 8 pages, a loopback memory and FIFO models,
// plus a standalone dram_page_checker instance for counter saturation.
module tb_dram_test_gen;

    localparam int NP = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        frq_write_en;
    logic [3:0]  frq_write_data;
    logic        frq_full = 1'b0;
    logic        fin_write_en;
    logic [31:0] fin_write_data;
    logic        fin_full = 1'b0;
    logic        fout_read_en;
    logic [31:0] fout_read_data = 32'd0;
    logic        fout_empty = 1'b1;
    logic        busy, done, mismatch;
    logic [7:0]  err_count;

    logic        chk_clear, chk_en, chk_mm;
    logic [31:0] chk_act, chk_exp;
    logic [7:0]  chk_err;

    int n_checks = 0;
    int n_fail = 0;

    // loopback environment state
    logic [31:0] mem [NP];
    logic [31:0] cval [NP];
    logic [7:0]  cmask = 8'h00;
    logic [3:0]  wreq [$];
    logic [31:0] wdat [$];
    logic [3:0]  rreq [$];
    logic [31:0] pend [$];
    logic [31:0] fq [$];
    int  depth = 16;
    int  stall_after = 0, stall_len = 0, stall_cnt = 0;
    bit  stall_fired = 1'b0, rbp = 1'b0, pop_pend = 1'b0;
    int  pops = 0, orphan = 0, bad_pop = 0, exp_err = 0;

    typedef struct {
        logic [7:0] corrupt;
        int         fdepth;
        int         s_after;
        int         s_len;
        bit         rand_bp;
        bit         start_mid;
        logic       exp_mm;
        logic [7:0] exp_err;
    } vec_t;

    dram_test_gen #(.LOG_DRAM_SIZE(8), .PAGE_LEN(32)) dut (
        .clk(clk), .rst(rst), .start(start),
        .frq_write_en(frq_write_en), .frq_write_data(frq_write_data), .frq_full(frq_full),
        .fin_write_en(fin_write_en), .fin_write_data(fin_write_data), .fin_full(fin_full),
        .fout_read_en(fout_read_en), .fout_read_data(fout_read_data), .fout_empty(fout_empty),
        .busy(busy), .done(done), .mismatch(mismatch), .err_count(err_count)
    );

    dram_page_checker #(.PAGE_LEN(32)) u_chk (
        .clk(clk), .rst(rst), .clear(chk_clear), .cmp_en(chk_en),
        .actual(chk_act), .expected(chk_exp), .mismatch(chk_mm), .err_count(chk_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {14'd0, frq_write_en, frq_write_data, fin_write_en, fin_write_data,
                fout_read_en, busy, done, mismatch, err_count};
    endfunction

    task automatic model_clear();
        wreq.delete(); wdat.delete(); rreq.delete(); pend.delete(); fq.delete();
        pops = 0; orphan = 0; bad_pop = 0; exp_err = 0; pop_pend = 1'b0;
        stall_cnt = 0; stall_fired = 1'b0;
    endtask

    // Memory + FIFO model, observing registered DUT pulses mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            pop_pend = 1'b0;
        end else begin
            if (pop_pend) begin
                if (fq.size() > 0) fq.delete(0);
                pops++;
            end
            pop_pend = fout_read_en;
            if (fout_read_en && fq.size() == 0) bad_pop++;
            if (frq_write_en) begin
                if (frq_write_data[0]) begin
                    wreq.push_back(frq_write_data);
                    wdat.push_back(fin_write_data);
                    if (!fin_write_en) orphan++;
                    mem[frq_write_data[3:1]] = fin_write_data;
                end else begin
                    rreq.push_back(frq_write_data);
                    if (fin_write_en) orphan++;
                    if (cmask[frq_write_data[3:1]]) begin
                        pend.push_back(cval[frq_write_data[3:1]]);
                        if (cval[frq_write_data[3:1]] != 32'(frq_write_data[3:1])) exp_err++;
                    end else begin
                        pend.push_back(mem[frq_write_data[3:1]]);
                        if (mem[frq_write_data[3:1]] != 32'(frq_write_data[3:1])) exp_err++;
                    end
                end
            end else if (fin_write_en) begin
                orphan++;
            end
            if (pend.size() > 0 && fq.size() < depth) begin
                fq.push_back(pend[0]);
                pend.delete(0);
            end
        end
        if (stall_len > 0 && !stall_fired && rreq.size() == stall_after) begin
            stall_cnt = stall_len;
            stall_fired = 1'b1;
        end
        if (stall_cnt > 0) begin
            frq_full = 1'b1;
            stall_cnt--;
        end else begin
            frq_full = rbp ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
        fin_full = rbp ? ($urandom_range(0, 3) == 0) : 1'b0;
        fout_empty = (fq.size() == 0);
        fout_read_data = (fq.size() > 0) ? fq[0] : 32'd0;
    end

    task automatic run_pass(input vec_t v, input bit use_table, input string tag);
        int cyc;
        bit mid_sent;
        model_clear();
        cmask = v.corrupt; depth = v.fdepth; stall_after = v.s_after; stall_len = v.s_len;
        rbp = v.rand_bp;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check({tag, "_start_state"}, {busy, done, mismatch, err_count}, {1'b1, 1'b0, 1'b0, 8'd0});
        cyc = 0; mid_sent = 1'b0;
        while (!done && cyc < 3000) begin
            if (v.start_mid && !mid_sent && wreq.size() >= 3) begin
                start = 1'b1; mid_sent = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk); cyc++;
        end
        start = 1'b0; rbp = 1'b0;
        check({tag, "_timeout"}, 64'(cyc < 3000), 64'd1);
        @(negedge clk);
        check({tag, "_n_writes"}, 64'(wreq.size()), 64'd8);
        check({tag, "_n_reads"}, 64'(rreq.size()), 64'd8);
        for (int i = 0; i < NP && i < wreq.size(); i++) begin
            check({tag, "_wr_req"}, 64'(wreq[i]), 64'((i << 1) | 1));
            check({tag, "_wr_data"}, 64'(wdat[i]), 64'(i));
        end
        for (int i = 0; i < NP && i < rreq.size(); i++)
            check({tag, "_rd_req"}, 64'(rreq[i]), 64'(i << 1));
        check({tag, "_drained"}, 64'(pops), 64'd8);
        check({tag, "_left_over"}, 64'(fq.size() + pend.size()), 64'd0);
        check({tag, "_orphan_bad_pop"}, 64'(orphan + bad_pop), 64'd0);
        check({tag, "_done_busy"}, {done, busy}, 2'b10);
        check({tag, "_mismatch"}, 64'(mismatch), 64'(exp_err > 0));
        check({tag, "_err_count"}, 64'(err_count), 64'((exp_err > 255) ? 255 : exp_err));
        if (use_table) begin
            check({tag, "_tbl_mismatch"}, 64'(mismatch), 64'(v.exp_mm));
            check({tag, "_tbl_err"}, 64'(err_count), 64'(v.exp_err));
        end
    endtask

    initial begin
        vec_t vecs [6];
        vec_t rv;
        int cyc;
        int nreq;
        vecs[0] = '{8'h00, 16, 0, 0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[1] = '{8'h20, 16, 0, 0, 1'b0, 1'b0, 1'b1, 8'd1};
        vecs[2] = '{8'h00, 16, 0, 0, 1'b0, 1'b1, 1'b0, 8'd0};
        vecs[3] = '{8'h00, 1, 2, 20, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[4] = '{8'hFF, 1, 0, 0, 1'b1, 1'b0, 1'b1, 8'd8};
        vecs[5] = '{8'h81, 2, 4, 5, 1'b1, 1'b1, 1'b1, 8'd2};
        for (int i = 0; i < NP; i++) begin cval[i] = 32'hFFFF_FFFF; mem[i] = 32'd0; end
        rst = 1'b1; start = 1'b0;
        chk_clear = 1'b0; chk_en = 1'b0; chk_act = 32'd0; chk_exp = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_outputs", all_outs(), 64'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_after_reset", all_outs(), 64'd0);
        check("idle_no_requests", 64'(wreq.size() + rreq.size()), 64'd0);

        // read data sitting in the FIFO while idle must stay there
        model_clear();
        fq.push_back(32'h1234); fq.push_back(32'h5678);
        repeat (10) @(negedge clk);
        check("idle_fout_untouched", 64'(fq.size()), 64'd2);
        check("idle_no_pop", 64'(pops), 64'd0);

        for (int i = 0; i < 6; i++) run_pass(vecs[i], 1'b1, $sformatf("vec%0d", i));

        // random corruption and backpressure against the loopback model
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < NP; i++)
                cval[i] = ($urandom_range(0, 1) == 0) ? 32'(i) : $urandom;
            rv = '{8'($urandom), int'($urandom_range(1, 4)), int'($urandom_range(0, 6)),
                   int'($urandom_range(0, 25)), 1'b1, 1'b0, 1'b0, 8'd0};
            run_pass(rv, 1'b0, $sformatf("rnd%0d", k));
        end
        for (int i = 0; i < NP; i++) cval[i] = 32'hFFFF_FFFF;

        // reset in the middle of the read phase
        model_clear(); cmask = 8'h00; depth = 16; stall_len = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 0;
        while (pops < 3 && cyc < 2000) begin @(negedge clk); cyc++; end
        check("midreset_reached_read", 64'(pops >= 3 && busy), 64'd1);
        rst = 1'b1;
        #1;
        check("midreset_async_zero", all_outs(), 64'd0);
        @(posedge clk); #1;
        check("midreset_edge_zero", all_outs(), 64'd0);
        @(negedge clk);
        nreq = wreq.size() + rreq.size();
        rst = 1'b0;
        model_clear();
        repeat (6) @(negedge clk);
        check("midreset_stays_idle", all_outs(), 64'd0);
        check("midreset_no_requests", 64'(wreq.size() + rreq.size()), 64'd0);
        check("midreset_had_traffic", 64'(nreq >= 11), 64'd1);
        run_pass(vecs[0], 1'b1, "after_reset");

        // standalone checker: err_count saturates at 255
        @(negedge clk); chk_clear = 1'b1;
        @(negedge clk); chk_clear = 1'b0;
        check("chk_cleared", {chk_mm, chk_err}, 9'd0);
        chk_en = 1'b1; chk_act = 32'd7; chk_exp = 32'd7;
        @(negedge clk);
        check("chk_match_no_count", {chk_mm, chk_err}, 9'd0);
        for (int n = 1; n <= 300; n++) begin
            chk_act = $urandom; chk_exp = ~chk_act;
            @(negedge clk);
            if (n == 1 || n == 254 || n == 255 || n == 256 || n == 300)
                check($sformatf("chk_sat_n%0d", n), {chk_mm, chk_err},
                      {1'b1, 8'((n > 255) ? 255 : n)});
        end
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
